// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output register with overrun and framing-error pulses.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t               state_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic [CNT_W-1:0]     clk_cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM, bit timing, shift register and output handshake register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            clk_cnt_r   <= {CNT_W{1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            // A load later in this block overrides the clear, so a new byte wins.
            if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_r   <= ST_START;
                        clk_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (clk_cnt_r == HALF_CNT) begin
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r   <= ST_DATA;
                            clk_cnt_r <= {CNT_W{1'b0}};
                            bit_idx_r <= {IDX_W{1'b0}};
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_r == LAST_CNT) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        // LSB arrives first, so shifting right lands it in bit 0.
                        shift_r   <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 1'b1;
                        if (bit_idx_r == LAST_IDX) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt_r == LAST_CNT) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                            if (!valid_r || ready_i) begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Held-low line: stay here so only one framing error is reported.
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule
